// File: rtl/mgpu_render_pkg.sv
// Shared render-pipeline types: coordinate width, coordinate type and the
// walker's state encoding.
package mgpu_render_pkg;

  localparam int COORD_W = 21;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/line_setup.sv
// Combinational Bresenham setup: deltas, step directions, initial error and
// step count from the latched segment endpoints.
module line_setup #(
  parameter int COORD_W = 21
) (
  input  logic signed [COORD_W-1:0] ax_i,
  input  logic signed [COORD_W-1:0] ay_i,
  input  logic signed [COORD_W-1:0] bx_i,
  input  logic signed [COORD_W-1:0] by_i,
  output logic        [COORD_W:0]   dx_o,
  output logic        [COORD_W:0]   dy_o,
  output logic                      sx_neg_o,
  output logic                      sy_neg_o,
  output logic signed [COORD_W+1:0] err0_o,
  output logic        [COORD_W:0]   cnt0_o
);

  logic signed [COORD_W:0] diff_x;
  logic signed [COORD_W:0] diff_y;

  // One extra bit holds the full difference of any two coordinates.
  assign diff_x = $signed({bx_i[COORD_W-1], bx_i}) - $signed({ax_i[COORD_W-1], ax_i});
  assign diff_y = $signed({by_i[COORD_W-1], by_i}) - $signed({ay_i[COORD_W-1], ay_i});

  assign sx_neg_o = diff_x[COORD_W];
  assign sy_neg_o = diff_y[COORD_W];
  assign dx_o     = diff_x[COORD_W] ? $unsigned(-diff_x) : $unsigned(diff_x);
  assign dy_o     = diff_y[COORD_W] ? $unsigned(-diff_y) : $unsigned(diff_y);
  assign err0_o   = $signed({1'b0, dx_o}) - $signed({1'b0, dy_o});
  assign cnt0_o   = (dx_o >= dy_o) ? dx_o : dy_o;

endmodule

// File: rtl/line_raster.sv
// Integer Bresenham line walker emitting one pixel per cycle on a
// valid/ready stream. Screen clipping is compiled in with LINE_RASTER_CLIP_EN.
module line_raster #(
  parameter int COORD_W = mgpu_render_pkg::COORD_W,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COORD_W-1:0] vtxA_X,
  input  logic signed [COORD_W-1:0] vtxA_Y,
  input  logic signed [COORD_W-1:0] vtxB_X,
  input  logic signed [COORD_W-1:0] vtxB_Y,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic signed [COORD_W-1:0] pix_X,
  output logic signed [COORD_W-1:0] pix_Y,
  output logic                      pix_last,
  output logic                      line_done,
  output logic                      busy
);
  import mgpu_render_pkg::*;

`ifdef LINE_RASTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  localparam logic signed [COORD_W-1:0] ONE_C = COORD_W'(1);
  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  state_e state_q, state_d;

  logic signed [COORD_W-1:0] ax_q, ay_q, bx_q, by_q;
  logic signed [COORD_W-1:0] cur_x_q, cur_y_q;
  logic        [COORD_W:0]   dx_q, dy_q, cnt_q;
  logic                      sx_neg_q, sy_neg_q;
  logic signed [COORD_W+1:0] err_q;
  logic                      line_done_q;

  logic        [COORD_W:0]   dx_s, dy_s, cnt0_s;
  logic                      sx_neg_s, sy_neg_s;
  logic signed [COORD_W+1:0] err0_s;

  logic signed [COORD_W+2:0] e2;
  logic                      step_x, step_y, cnt_zero, in_range, vis, adv;
  logic signed [COORD_W+1:0] err_d;

  line_setup #(.COORD_W(COORD_W)) u_setup (
    .ax_i    (ax_q),
    .ay_i    (ay_q),
    .bx_i    (bx_q),
    .by_i    (by_q),
    .dx_o    (dx_s),
    .dy_o    (dy_s),
    .sx_neg_o(sx_neg_s),
    .sy_neg_o(sy_neg_s),
    .err0_o  (err0_s),
    .cnt0_o  (cnt0_s)
  );

  assign cnt_zero = (cnt_q == '0);
  assign in_range = !cur_x_q[COORD_W-1] && (cur_x_q <= X_MAX) &&
                    !cur_y_q[COORD_W-1] && (cur_y_q <= Y_MAX);
  assign vis      = !CLIP_EN || in_range;

  // Both axis decisions use the same pre-step doubled error.
  assign e2     = $signed({err_q, 1'b0});
  assign step_x = e2 > -$signed({2'b00, dy_q});
  assign step_y = e2 < $signed({2'b00, dx_q});
  assign err_d  = err_q - (step_x ? $signed({1'b0, dy_q}) : '0)
                        + (step_y ? $signed({1'b0, dx_q}) : '0);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = RUN;
      RUN:     if (adv && cnt_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Invisible steps are skipped without waiting on downstream.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    adv       = 1'b0;
    case (state_q)
      IDLE:  cmd_ready = 1'b1;
      SETUP: busy = 1'b1;
      RUN: begin
        busy      = 1'b1;
        pix_valid = vis;
        pix_last  = vis && cnt_zero;
        adv       = pix_ready || !vis;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ax_q        <= '0;
      ay_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cnt_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      err_q       <= '0;
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= adv && cnt_zero;
      if (state_q == IDLE && cmd_valid) begin
        ax_q <= vtxA_X;
        ay_q <= vtxA_Y;
        bx_q <= vtxB_X;
        by_q <= vtxB_Y;
      end
      if (state_q == SETUP) begin
        dx_q     <= dx_s;
        dy_q     <= dy_s;
        sx_neg_q <= sx_neg_s;
        sy_neg_q <= sy_neg_s;
        err_q    <= err0_s;
        cnt_q    <= cnt0_s;
        cur_x_q  <= ax_q;
        cur_y_q  <= ay_q;
      end
      if (adv && !cnt_zero) begin
        err_q <= err_d;
        cnt_q <= cnt_q - 1'b1;
        if (step_x) cur_x_q <= sx_neg_q ? cur_x_q - ONE_C : cur_x_q + ONE_C;
        if (step_y) cur_y_q <= sy_neg_q ? cur_y_q - ONE_C : cur_y_q + ONE_C;
      end
    end
  end

  assign pix_X     = cur_x_q;
  assign pix_Y     = cur_y_q;
  assign line_done = line_done_q;

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster: directed segments from the test plan
// plus randomized segments/backpressure against a behavioural line model.
module tb_line_raster;

  localparam int W = 21;

  logic                CLK = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic signed [W-1:0] vtxA_X, vtxA_Y, vtxB_X, vtxB_Y;
  logic                pix_valid;
  logic                pix_ready;
  logic signed [W-1:0] pix_X, pix_Y;
  logic                pix_last;
  logic                line_done;
  logic                busy;

  line_raster dut (
    .CLK(CLK), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .vtxA_X(vtxA_X), .vtxA_Y(vtxA_Y), .vtxB_X(vtxB_X), .vtxB_Y(vtxB_Y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_X(pix_X), .pix_Y(pix_Y),
    .pix_last(pix_last), .line_done(line_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  int exp_x[$], exp_y[$];
  bit exp_last[$];
  int obs_x[$], obs_y[$];
  bit obs_last[$];
  int done_cnt, first_pv_k, last_push_k, done_k, stall_bad, ready_at_done, timed_out;

  function automatic bit on_screen(int x, int y);
`ifdef LINE_RASTER_CLIP_EN
    return (x >= 0) && (x <= 639) && (y >= 0) && (y <= 479);
`else
    return 1'b1;
`endif
  endfunction

  // Reference walk in plain integers; visible steps only.
  task automatic model_line(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, n, x, y, e2;
    exp_x.delete(); exp_y.delete(); exp_last.delete();
    dx = (bx > ax) ? bx - ax : ax - bx;
    dy = (by > ay) ? by - ay : ay - by;
    sx = (bx >= ax) ? 1 : -1;
    sy = (by >= ay) ? 1 : -1;
    n = (dx > dy) ? dx : dy;
    err = dx - dy;
    x = ax; y = ay;
    for (int i = 0; i <= n; i++) begin
      if (on_screen(x, y)) begin
        exp_x.push_back(x); exp_y.push_back(y); exp_last.push_back(i == n);
      end
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += sy; end
    end
  endtask

  task automatic drive_line(input int ax, input int ay, input int bx, input int by,
                            input int ready_pct);
    int n, budget, tail;
    bit r, stalled;
    int sxv, syv;
    bit slast;
    obs_x.delete(); obs_y.delete(); obs_last.delete();
    done_cnt = 0; first_pv_k = -1; last_push_k = -1; done_k = -1;
    stall_bad = 0; ready_at_done = -1; timed_out = 0;
    stalled = 0; tail = 0; sxv = 0; syv = 0; slast = 0;
    n = ((bx > ax) ? bx - ax : ax - bx);
    if (((by > ay) ? by - ay : ay - by) > n) n = (by > ay) ? by - ay : ay - by;
    budget = 4 * (n + 1) + 40;
    @(negedge CLK);
    cmd_valid = 1'b1;
    vtxA_X = W'(ax); vtxA_Y = W'(ay); vtxB_X = W'(bx); vtxB_Y = W'(by);
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (pix_valid && first_pv_k < 0) first_pv_k = k;
      if (stalled && (int'(pix_X) != sxv || int'(pix_Y) != syv || pix_last != slast || !pix_valid))
        stall_bad++;
      if (line_done) begin
        done_cnt++; done_k = k; ready_at_done = cmd_ready;
      end
      r = ($urandom_range(99) < ready_pct);
      pix_ready = r;
      if (pix_valid && r) begin
        obs_x.push_back(int'(pix_X)); obs_y.push_back(int'(pix_Y));
        obs_last.push_back(pix_last); last_push_k = k;
      end
      stalled = pix_valid && !r;
      sxv = int'(pix_X); syv = int'(pix_Y); slast = pix_last;
      if (done_cnt > 0) begin
        tail++;
        if (tail > 3) break;
      end
      @(negedge CLK);
    end
    if (done_cnt == 0) timed_out = 1;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; pix_ready = 1'b1;
    vtxA_X = '0; vtxA_Y = '0; vtxB_X = '0; vtxB_Y = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || pix_valid !== 1'b0 || pix_X !== '0 || pix_Y !== '0 ||
        pix_last !== 1'b0 || line_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got rdy=%b pv=%b x=%0d y=%0d last=%b done=%b busy=%b want 1 0 0 0 0 0 0",
               cmd_ready, pix_valid, pix_X, pix_Y, pix_last, line_done, busy);
    end
    @(negedge CLK);
    rst = 1'b0;
    $display("test_reset: reset state checked");
  endtask

  task automatic test_horizontal;
    drive_line(0, 0, 3, 0, 100);
    checks++;
    if (obs_x.size() != 4) begin
      fails++; $display("FAIL horiz_count got %0d want 4", obs_x.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_x[i] != i || obs_y[i] != 0 || obs_last[i] != (i == 3)) begin
          fails++;
          $display("FAIL horiz_pix[%0d] got (%0d,%0d,last=%b) want (%0d,0,last=%b)",
                   i, obs_x[i], obs_y[i], obs_last[i], i, i == 3);
        end
      end
    end
    checks++;
    if (first_pv_k != 2) begin
      fails++; $display("FAIL horiz_latency got %0d want 2", first_pv_k);
    end
    checks++;
    if (last_push_k - first_pv_k != 3) begin
      fails++; $display("FAIL horiz_throughput got span %0d want 3", last_push_k - first_pv_k);
    end
    checks++;
    if (done_cnt != 1 || done_k != last_push_k + 1 || ready_at_done != 1 || timed_out != 0) begin
      fails++;
      $display("FAIL horiz_done got pulses=%0d at=%0d rdy=%0d to=%0d want 1 at %0d rdy=1 to=0",
               done_cnt, done_k, ready_at_done, timed_out, last_push_k + 1);
    end
    $display("test_horizontal: %0d pixels, first at cycle %0d", obs_x.size(), first_pv_k);
  endtask

  task automatic test_steep;
    int ex[6] = '{2, 2, 1, 1, 0, 0};
    int ey[6] = '{5, 4, 3, 2, 1, 0};
    drive_line(2, 5, 0, 0, 100);
    checks++;
    if (obs_x.size() != 6) begin
      fails++; $display("FAIL steep_count got %0d want 6", obs_x.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_x[i] != ex[i] || obs_y[i] != ey[i] || obs_last[i] != (i == 5)) begin
          fails++;
          $display("FAIL steep_pix[%0d] got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)",
                   i, obs_x[i], obs_y[i], obs_last[i], ex[i], ey[i], i == 5);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || timed_out != 0) begin
      fails++; $display("FAIL steep_done got %0d pulses want 1", done_cnt);
    end
    $display("test_steep: %0d pixels", obs_x.size());
  endtask

  task automatic test_degenerate;
    drive_line(7, 9, 7, 9, 100);
    checks++;
    if (obs_x.size() != 1 || obs_x[0] != 7 || obs_y[0] != 9 || obs_last[0] != 1'b1) begin
      fails++;
      $display("FAIL degen_pix got %0d pixels first=(%0d,%0d,last=%b) want 1 pixel (7,9,last=1)",
               obs_x.size(), (obs_x.size() > 0) ? obs_x[0] : -999,
               (obs_y.size() > 0) ? obs_y[0] : -999, (obs_last.size() > 0) ? obs_last[0] : 1'b0);
    end
    checks++;
    if (done_cnt != 1 || ready_at_done != 1) begin
      fails++; $display("FAIL degen_done got pulses=%0d rdy=%0d want 1 1", done_cnt, ready_at_done);
    end
    $display("test_degenerate: %0d pixels", obs_x.size());
  endtask

  task automatic test_backpressure;
    model_line(0, 0, 10, 4);
    drive_line(0, 0, 10, 4, 50);
    checks++;
    if (obs_x.size() != exp_x.size() || exp_x.size() != 11) begin
      fails++; $display("FAIL bp_count got %0d want 11", obs_x.size());
    end else begin
      for (int i = 0; i < exp_x.size(); i++) begin
        checks++;
        if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_last[i] != exp_last[i]) begin
          fails++;
          $display("FAIL bp_pix[%0d] got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)",
                   i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_y[i], exp_last[i]);
        end
      end
    end
    checks++;
    if (stall_bad != 0 || done_cnt != 1) begin
      fails++; $display("FAIL bp_stall got unstable=%0d pulses=%0d want 0 1", stall_bad, done_cnt);
    end
    $display("test_backpressure: %0d pixels under random ready", obs_x.size());
  endtask

  task automatic test_reset_mid;
    int hs, seen_done;
    hs = 0; seen_done = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; pix_ready = 1'b1;
    vtxA_X = W'(0); vtxA_Y = W'(0); vtxB_X = W'(9); vtxB_Y = W'(0);
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && hs < 2; k++) begin
      if (pix_valid) hs++;
      if (hs < 2) @(negedge CLK);
    end
    @(posedge CLK);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || line_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_abort got pv=%b done=%b busy=%b want 0 0 0", pix_valid, line_done, busy);
    end
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (line_done || pix_valid) seen_done++;
      @(negedge CLK);
    end
    checks++;
    if (cmd_ready !== 1'b1 || seen_done != 0) begin
      fails++;
      $display("FAIL rstmid_idle got rdy=%b stray=%0d want rdy=1 stray=0", cmd_ready, seen_done);
    end
    drive_line(1, 1, 1, 1, 100);
    checks++;
    if (obs_x.size() != 1 || obs_x[0] != 1 || obs_y[0] != 1 || obs_last[0] != 1'b1 || done_cnt != 1) begin
      fails++;
      $display("FAIL rstmid_next got %0d pixels, %0d pulses want 1 pixel (1,1) last, 1 pulse",
               obs_x.size(), done_cnt);
    end
    $display("test_reset_mid: aborted after %0d handshakes", hs);
  endtask

  task automatic test_clip;
    int want_n;
`ifdef LINE_RASTER_CLIP_EN
    want_n = 3;
`else
    want_n = 5;
`endif
    model_line(-2, 0, 2, 0);
    drive_line(-2, 0, 2, 0, 100);
    checks++;
    if (obs_x.size() != want_n || exp_x.size() != want_n) begin
      fails++; $display("FAIL clip_count got %0d want %0d", obs_x.size(), want_n);
    end else begin
      for (int i = 0; i < want_n; i++) begin
        checks++;
        if (obs_x[i] != exp_x[i] || obs_y[i] != 0 || obs_last[i] != exp_last[i]) begin
          fails++;
          $display("FAIL clip_pix[%0d] got (%0d,%0d,last=%b) want (%0d,0,last=%b)",
                   i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_last[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL clip_done got %0d pulses want 1", done_cnt);
    end
    $display("test_clip: %0d pixels emitted", obs_x.size());
  endtask

  task automatic test_random;
    int ax, ay, bx, by, pct, bad;
    for (int t = 0; t < 14; t++) begin
      ax = $urandom_range(680) - 20;
      ay = $urandom_range(520) - 20;
      bx = ax + $urandom_range(120) - 60;
      by = ay + $urandom_range(120) - 60;
      pct = (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 70 : 35);
      model_line(ax, ay, bx, by);
      drive_line(ax, ay, bx, by, pct);
      bad = 0;
      checks++;
      if (obs_x.size() != exp_x.size()) begin
        fails++; bad = 1;
        $display("FAIL rand%0d_count got %0d want %0d", t, obs_x.size(), exp_x.size());
      end else begin
        for (int i = 0; i < exp_x.size(); i++) begin
          checks++;
          if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_last[i] != exp_last[i]) begin
            fails++; bad = 1;
            $display("FAIL rand%0d_pix[%0d] got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)",
                     t, i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_y[i], exp_last[i]);
          end
        end
      end
      checks++;
      if (done_cnt != 1 || stall_bad != 0 || timed_out != 0) begin
        fails++; bad = 1;
        $display("FAIL rand%0d_ctrl got pulses=%0d unstable=%0d to=%0d want 1 0 0",
                 t, done_cnt, stall_bad, timed_out);
      end
      $display("test_random[%0d]: (%0d,%0d)->(%0d,%0d) ready=%0d%% pixels=%0d %s",
               t, ax, ay, bx, by, pct, obs_x.size(), bad ? "bad" : "ok");
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_degenerate();
    test_backpressure();
    test_reset_mid();
    test_clip();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
